// File: rtl/irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : irq_sequencer
// Purpose  : Picks one pending interrupt line (fixed priority or round-robin),
//            delivers it to the core over req/ack, pulses a one-hot clear and
//            waits a programmable hold-off. Optional ack timeout under
//            IRQ_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_LINES      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0]    PADDR,
    input  logic [31:0]                  PWDATA,
    input  logic                         PWRITE,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    output logic [31:0]                  PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    input  logic [NUM_LINES-1:0]         irq_pending_i,
    output logic                         irq_req_o,
    output logic [$clog2(NUM_LINES)-1:0] irq_id_o,
    input  logic                         irq_ack_i,
    output logic [NUM_LINES-1:0]         irq_clear_o
);

    localparam int ID_W = $clog2(NUM_LINES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [7:0]      hcnt_q, hcnt_d;
    logic            en_q, en_d;
    logic            rr_q, rr_d;
    logic [7:0]      holdoff_q, holdoff_d;

    logic            apb_wr;
    logic [ID_W-1:0] winner;
    logic            found;
    logic [ID_W-1:0] next_ptr;
    logic [31:0]     status;
    logic            to_set;
    logic            unused_bits;

`ifdef IRQ_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            to_flag_q, to_flag_d;
    assign unused_bits = ^{PADDR, PWDATA};
`else
    assign unused_bits = ^{PADDR, PWDATA, 1'(TIMEOUT_CYCLES)};
`endif

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign apb_wr  = PSEL & PENABLE & PWRITE;
    assign next_ptr = (id_q == ID_W'(NUM_LINES - 1)) ? '0 : id_q + ID_W'(1);

    // Scan order starts at the pointer in RR mode, at line 0 otherwise
    always_comb begin
        int            idx;
        logic [ID_W-1:0] sel;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            idx = rr_q ? int'(ptr_q) + i : i;
            if (idx >= NUM_LINES) begin
                idx = idx - NUM_LINES;
            end
            sel = ID_W'(idx);
            if (!found && irq_pending_i[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            en_q      <= 1'b0;
            rr_q      <= 1'b0;
            holdoff_q <= '0;
`ifdef IRQ_SEQ_TIMEOUT_EN
            tcnt_q    <= '0;
            to_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            en_q      <= en_d;
            rr_q      <= rr_d;
            holdoff_q <= holdoff_d;
`ifdef IRQ_SEQ_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            to_flag_q <= to_flag_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hcnt_d  = hcnt_q;
        to_set  = 1'b0;
`ifdef IRQ_SEQ_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en_q && found) begin
                    id_d    = winner;
                    state_d = ST_REQ;
`ifdef IRQ_SEQ_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            ST_REQ: begin
                if (irq_ack_i) begin
                    state_d = ST_CLEAR;
`ifdef IRQ_SEQ_TIMEOUT_EN
                end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon without clearing; skip past this line next time
                    state_d = ST_IDLE;
                    to_set  = 1'b1;
                    ptr_d   = next_ptr;
                end else begin
                    tcnt_d  = tcnt_q + TO_W'(1);
`endif
                end
            end
            ST_CLEAR: begin
                ptr_d   = next_ptr;
                hcnt_d  = holdoff_q;
                state_d = (holdoff_q != 8'd0) ? ST_HOLD : ST_IDLE;
            end
            default: begin
                if (hcnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    hcnt_d  = hcnt_q - 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        irq_req_o   = (state_q == ST_REQ);
        irq_id_o    = id_q;
        irq_clear_o = '0;
        if (state_q == ST_CLEAR) begin
            irq_clear_o[id_q] = 1'b1;
        end
    end

    always_comb begin
        en_d      = en_q;
        rr_d      = rr_q;
        holdoff_d = holdoff_q;
        if (apb_wr && PADDR[3:2] == 2'd0) begin
            en_d = PWDATA[0];
            rr_d = PWDATA[1];
        end
        if (apb_wr && PADDR[3:2] == 2'd1) begin
            holdoff_d = PWDATA[7:0];
        end
`ifdef IRQ_SEQ_TIMEOUT_EN
        to_flag_d = to_flag_q;
        if (apb_wr && PADDR[3:2] == 2'd2 && PWDATA[16]) begin
            to_flag_d = 1'b0;
        end
        if (to_set) begin
            to_flag_d = 1'b1;
        end
`endif
    end

    always_comb begin
        status          = '0;
        status[0]       = (state_q != ST_IDLE);
        status[8 +: ID_W] = id_q;
`ifdef IRQ_SEQ_TIMEOUT_EN
        status[16]      = to_flag_q;
`endif
        PRDATA = '0;
        if (PSEL) begin
            case (PADDR[3:2])
                2'd0:    PRDATA = {30'd0, rr_q, en_q};
                2'd1:    PRDATA = {24'd0, holdoff_q};
                2'd2:    PRDATA = status;
                default: PRDATA = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
